rx_timer_ctrl: RTL

Sequencing controller for serial-receive bit timing. Once a start edge is detected, it drives two counters: a per-bit clock divider and a bit counter. It aligns sampling to mid-bit and emits a one-cycle `shift_strobe` per data bit, then checks the stop bit and flags `packet_done` / `framing_error`. It sits between the line edge detector and the receive shift register.

---
 rtl/rx_timer_pkg.sv | 19 +
 rtl/flex_counter.sv | 43 ++++
 rtl/rx_timer_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rx_timer_pkg.sv
// ---------------------------------------------------------------------------
// rx_timer_pkg
// Shared definitions for the serial-receive bit-timing controller:
//   state_t  : controller FSM states
//   MIN_CLKS : smallest usable clocks-per-bit; smaller requests are raised
//              to this so the half-bit alignment period is never zero.
// ---------------------------------------------------------------------------
package rx_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START_ALIGN,
        DATA,
        STOP
    } state_t;

    localparam int MIN_CLKS = 2;

endpackage

// File: rtl/flex_counter.sv
// ---------------------------------------------------------------------------
// flex_counter
// Generic up-counter with a programmable last value.
// Ports:
//   clk           : system clock, rising edge
//   n_rst         : asynchronous active-low reset, clears the count
//   clear         : synchronous clear, dominates count_enable
//   count_enable  : advance the count by one this cycle
//   rollover_val  : last value of the count sequence
//   count         : current count
//   rollover_flag : high while count equals rollover_val
// ---------------------------------------------------------------------------
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    // Reaching rollover_val while enabled returns the count to zero, so the
    // count can never run past the programmed last value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

    assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/rx_timer_ctrl.sv
// ---------------------------------------------------------------------------
// rx_timer_ctrl
// Bit-timing sequencer for a serial receiver. After a start edge it waits
// half a bit to land on mid-bit, confirms the start bit, issues one shift
// strobe per data bit and finally checks the stop bit.
// Ports:
//   clk           : system clock, rising edge
//   n_rst         : asynchronous active-low reset
//   start_edge    : one-cycle pulse, line fell while idle
//   rx_in         : synchronized serial line
//   abort         : synchronous cancel, returns to IDLE at the next edge
//   clks_per_bit  : clocks per bit, captured when a start is accepted
//   shift_strobe  : one-cycle pulse, shift register samples rx_in now
//   packet_done   : one-cycle pulse in the last stop-bit cycle
//   framing_error : stop bit was low; held until the next accepted start
//   busy          : controller is not idle
// ---------------------------------------------------------------------------
module rx_timer_ctrl
    import rx_timer_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_edge,
    input  logic             rx_in,
    input  logic             abort,
    input  logic [CNT_W-1:0] clks_per_bit,
    output logic             shift_strobe,
    output logic             packet_done,
    output logic             framing_error,
    output logic             busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cfg;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] div_last_val;
    logic [CNT_W-1:0] div_cnt;
    logic             div_last;
    logic             div_clear;
    logic [BIT_W-1:0] bit_cnt;
    logic             bit_last;
    logic             bit_clear;
    logic             strobe_due;
    logic             done_due;
    logic             start_accept;

    assign half         = cfg >> 1;
    assign start_accept = (state == IDLE) && start_edge && !abort;

    // The alignment phase counts half a bit; data and stop phases count a
    // full bit. Counting starts at zero, so the last cycle is length - 1.
    assign div_last_val = (state == START_ALIGN) ? (half - CNT_W'(1))
                                                 : (cfg - CNT_W'(1));

    assign strobe_due = (state == DATA) && div_last;
    assign done_due   = (state == STOP) && div_last;

    // The divider restarts on every state change and at each data-bit
    // boundary; it is held at zero while idle.
    assign div_clear = (next_state != state) || (state == IDLE) || strobe_due;

    // Bit count is only meaningful in DATA, so it sits at zero elsewhere and
    // therefore starts from zero on every DATA entry.
    assign bit_clear = (state != DATA);

    flex_counter #(
        .WIDTH(CNT_W)
    ) u_div_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (div_clear),
        .count_enable (state != IDLE),
        .rollover_val (div_last_val),
        .count        (div_cnt),
        .rollover_flag(div_last)
    );

    flex_counter #(
        .WIDTH(BIT_W)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (bit_clear),
        .count_enable (strobe_due),
        .rollover_val (BIT_W'(DATA_BITS - 1)),
        .count        (bit_cnt),
        .rollover_flag(bit_last)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Abort overrides every other transition.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        next_state = START_ALIGN;
                    end
                end
                START_ALIGN: begin
                    if (div_last) begin
                        next_state = rx_in ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (div_last && bit_last) begin
                        next_state = STOP;
                    end
                end
                STOP: begin
                    if (div_last) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Bit period is captured once per frame and raised to MIN_CLKS so the
    // half-bit alignment is at least one cycle long.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cfg <= '0;
        end else if (start_accept) begin
            if (clks_per_bit < CNT_W'(MIN_CLKS)) begin
                cfg <= CNT_W'(MIN_CLKS);
            end else begin
                cfg <= clks_per_bit;
            end
        end
    end

    // Framing error reflects the most recent stop bit and is wiped when a
    // new frame begins; an aborted stop cycle leaves it untouched.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            framing_error <= 1'b0;
        end else if (start_accept) begin
            framing_error <= 1'b0;
        end else if (done_due && !abort) begin
            framing_error <= !rx_in;
        end
    end

    // Pulses come from registered state and counts; abort only masks them
    // so a cancelled frame never produces a partial strobe or done.
    assign shift_strobe = strobe_due && !abort;
    assign packet_done  = done_due && !abort;
    assign busy         = (state != IDLE);

endmodule
